// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator.
// Compares two words MSB-first, one bit pair per clock, and latches the
// first unequal bit pair. The latency is always WIDTH+1 cycles from start to
// done, whatever the data. The gt/eq/lt result is registered and stays
// valid until the next accepted start.
//
// Handshake: start is accepted on a rising edge only when the block is in
// IDLE or DONE. The block samples a_in/b_in only on that edge. busy is high
// for exactly WIDTH cycles after the accepting edge. done then pulses for one
// cycle, and the results become valid in that cycle. start is ignored while
// busy is high.

// Single-bit comparator cell. Exactly one output is high.
module onebit_comparator (
  input  logic i_a,
  input  logic i_b,
  output logic o_agb,
  output logic o_eg,
  output logic o_alb
);
  // Pure combinational decode of one bit pair
  always_comb begin
    o_agb = i_a & ~i_b;
    o_alb = ~i_a & i_b;
    o_eg  = ~(i_a ^ i_b);
  end
endmodule

module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             agb,
  output logic             eg,
  output logic             alb
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CW-1:0]   r_cnt;
  logic            r_decided;
  logic            r_gt;
  logic            r_lt;
  logic            r_agb;
  logic            r_eg;
  logic            r_alb;

  logic            w_accept;
  logic            w_last;
  logic            w_cell_agb;
  logic            w_cell_eg;
  logic            w_cell_alb;
  logic            w_decided_next;
  logic            w_gt_next;
  logic            w_lt_next;

  // The cell always looks at the current MSB of the shift registers
  onebit_comparator u_cell (
    .i_a   (r_sa[WIDTH-1]),
    .i_b   (r_sb[WIDTH-1]),
    .o_agb (w_cell_agb),
    .o_eg  (w_cell_eg),
    .o_alb (w_cell_alb)
  );

  // Decision logic: only the first unequal bit pair counts, and later bits are ignored
  always_comb begin
    w_accept       = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    w_last         = (r_cnt == '0);
    w_decided_next = r_decided | w_cell_agb | w_cell_alb;
    w_gt_next      = r_gt | (~r_decided & w_cell_agb);
    w_lt_next      = r_lt | (~r_decided & w_cell_alb);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_SHIFT;
      S_SHIFT: if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_SHIFT : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: load on accept, shift and decide in SHIFT, register the result on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa      <= '0;
      r_sb      <= '0;
      r_cnt     <= '0;
      r_decided <= 1'b0;
      r_gt      <= 1'b0;
      r_lt      <= 1'b0;
      r_agb     <= 1'b0;
      r_eg      <= 1'b0;
      r_alb     <= 1'b0;
    end else if (w_accept) begin
      r_sa      <= a_in;
      r_sb      <= b_in;
      r_cnt     <= CW'(WIDTH - 1);
      r_decided <= 1'b0;
      r_gt      <= 1'b0;
      r_lt      <= 1'b0;
      r_agb     <= 1'b0;
      r_eg      <= 1'b0;
      r_alb     <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_sa      <= r_sa << 1;
      r_sb      <= r_sb << 1;
      r_cnt     <= r_cnt - 1'b1;
      r_decided <= w_decided_next;
      r_gt      <= w_gt_next;
      r_lt      <= w_lt_next;
      if (w_last) begin
        r_agb <= w_gt_next;
        r_alb <= w_lt_next;
        r_eg  <= ~(w_gt_next | w_lt_next);
      end
    end
  end

  // Outputs are decodes of registered state only
  always_comb begin
    busy = (r_state == S_SHIFT);
    done = (r_state == S_DONE);
    agb  = r_agb;
    eg   = r_eg;
    alb  = r_alb;
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator (WIDTH=8 and WIDTH=1 instances).
module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8, done8, agb8, eg8, alb8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       busy1, done1, agb1, eg1, alb1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       agb;
    logic       eg;
    logic       alb;
  } vec_t;

  vec_t vecs[8];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  serial_magnitude_comparator #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8),
    .busy(busy8), .done(done8), .agb(agb8), .eg(eg8), .alb(alb8)
  );

  serial_magnitude_comparator #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1),
    .busy(busy1), .done(done1), .agb(agb1), .eg(eg1), .alb(alb1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Full WIDTH=8 compare with per-cycle timing checks; optional start pulses in busy cycles 3 and 5
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic ea, input logic ee, input logic el,
                      input string nm, input bit pulse_mid);
    int n_done;
    n_done = 0;
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) start8 = 1'b0;
      if (pulse_mid) begin
        if (k == 3 || k == 5) begin start8 = 1'b1; a8 = ~a; b8 = ~b ^ 8'h01; end
        else if (k == 4 || k == 6) start8 = 1'b0;
      end
      if (done8) n_done++;
      if (k <= 8) begin
        chk({nm, " busy"}, {31'd0, busy8}, 32'd1);
        chk({nm, " done_early"}, {31'd0, done8}, 32'd0);
        if (k == 1) chk({nm, " cleared"}, {29'd0, agb8, eg8, alb8}, 32'd0);
      end else if (k == 9) begin
        chk({nm, " done"}, {31'd0, done8}, 32'd1);
        chk({nm, " busy_in_done"}, {31'd0, busy8}, 32'd0);
        chk({nm, " result"}, {29'd0, agb8, eg8, alb8}, {29'd0, ea, ee, el});
      end else begin
        chk({nm, " done_after"}, {31'd0, done8}, 32'd0);
        chk({nm, " held"}, {29'd0, agb8, eg8, alb8}, {29'd0, ea, ee, el});
      end
    end
    chk({nm, " done_count"}, n_done, 32'd1);
  endtask

  task automatic run1(input logic a, input logic b,
                      input logic ea, input logic ee, input logic el, input string nm);
    @(negedge clk);
    a1 = a; b1 = b; start1 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) start1 = 1'b0;
      if (k == 1) begin
        chk({nm, " busy"}, {31'd0, busy1}, 32'd1);
        chk({nm, " done_early"}, {31'd0, done1}, 32'd0);
      end else if (k == 2) begin
        chk({nm, " done"}, {31'd0, done1}, 32'd1);
        chk({nm, " result"}, {29'd0, agb1, eg1, alb1}, {29'd0, ea, ee, el});
      end else begin
        chk({nm, " done_after"}, {31'd0, done1}, 32'd0);
      end
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 8'h3D, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h7F, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0};

    // reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset8", {27'd0, busy8, done8, agb8, eg8, alb8}, 32'd0);
    chk("reset1", {27'd0, busy1, done1, agb1, eg1, alb1}, 32'd0);
    rst = 1'b0;

    // table-driven compares
    for (int i = 0; i < 8; i++)
      run8(vecs[i].a, vecs[i].b, vecs[i].agb, vecs[i].eg, vecs[i].alb,
           $sformatf("vec%0d", i), 1'b0);

    // start pulses during busy are ignored
    run8(8'h3C, 8'h3D, 1'b0, 1'b0, 1'b1, "ignore_start", 1'b1);

    // reset in the 4th busy cycle aborts the compare
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) start8 = 1'b0;
      if (k <= 4) chk("abort busy", {31'd0, busy8}, 32'd1);
      if (k == 4) rst = 1'b1;
      if (k == 5) begin
        rst = 1'b0;
        chk("abort outputs", {27'd0, busy8, done8, agb8, eg8, alb8}, 32'd0);
      end
      if (k > 5) chk("abort no_done", {30'd0, busy8, done8}, 32'd0);
    end
    run8(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, "after_abort", 1'b0);

    // rst wins over start on the same edge
    @(negedge clk);
    rst = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    chk("rst_priority", {27'd0, busy8, done8, agb8, eg8, alb8}, 32'd0);

    // back-to-back with start held high
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) begin a8 = 8'h20; b8 = 8'h10; end
      if (k == 9) begin
        chk("b2b done1", {31'd0, done8}, 32'd1);
        chk("b2b res1", {29'd0, agb8, eg8, alb8}, 32'b001);
      end else if (k == 10) begin
        chk("b2b restart busy", {31'd0, busy8}, 32'd1);
        chk("b2b cleared", {29'd0, agb8, eg8, alb8}, 32'd0);
      end else if (k == 18) begin
        start8 = 1'b0;
        chk("b2b done2", {31'd0, done8}, 32'd1);
        chk("b2b res2", {29'd0, agb8, eg8, alb8}, 32'b100);
      end else begin
        chk("b2b no_done", {31'd0, done8}, 32'd0);
      end
    end
    @(negedge clk);
    chk("b2b idle", {30'd0, busy8, done8}, 32'd0);

    // WIDTH=1, all four bit pairs
    run1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "w1_10");
    run1(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "w1_01");
    run1(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "w1_00");
    run1(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "w1_11");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
